// File: rtl/spi_write_sequencer_if.sv
// spi_write_sequencer_if: requester handshakes, status flags and SPI lines of the write sequencer.
interface spi_write_sequencer_if;
    logic       req0, ack0, req1, ack1;
    logic [6:0] addr0, addr1;
    logic [7:0] data0, data1;
    logic       busy, done;
    logic       sclk, copi, cs_n;

    modport master (
        input  req0, addr0, data0, req1, addr1, data1,
        output ack0, ack1, busy, done, sclk, copi, cs_n
    );

    modport slave (
        output req0, addr0, data0, req1, addr1, data1,
        input  ack0, ack1, busy, done, sclk, copi, cs_n
    );
endinterface

// File: rtl/spi_write_sequencer.sv
// spi_write_sequencer: round-robin arbiter between two write requesters that serializes
// each granted payload into a 17-pulse SPI mode-0 write frame (16 data bits + commit).
module spi_write_sequencer #(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    spi_write_sequencer_if.master bus
);
    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;

    localparam logic [7:0] DIV_END    = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_END    = 8'(GAP_CYCLES - 1);
    localparam logic [4:0] LAST_PULSE = 5'd16;

    state_t      state, state_nx;
    logic [7:0]  cnt, cnt_nx;
    logic [4:0]  pulse, pulse_nx;
    logic [14:0] shreg, shreg_nx;
    logic        last, last_nx;
    logic        sclk_q, sclk_nx, copi_q, copi_nx, cs_n_q, cs_n_nx;
    logic        ack0_q, ack0_nx, ack1_q, ack1_nx, done_q, done_nx, busy_q;
    logic        g0, g1;
    logic [15:0] word;

    // with both requesting, the side not granted last time wins
    assign g0   = bus.req0 && (!bus.req1 || last);
    assign g1   = bus.req1 && (!bus.req0 || !last);
    assign word = g1 ? {1'b1, bus.addr1, bus.data1} : {1'b1, bus.addr0, bus.data0};

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + 8'd1;
        pulse_nx = pulse;
        shreg_nx = shreg;
        last_nx  = last;
        sclk_nx  = sclk_q;
        copi_nx  = copi_q;
        cs_n_nx  = cs_n_q;
        ack0_nx  = 1'b0;
        ack1_nx  = 1'b0;
        done_nx  = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_nx = '0;
                if (g0 || g1) begin
                    state_nx = SETUP;
                    shreg_nx = word[14:0];
                    copi_nx  = word[15];
                    cs_n_nx  = 1'b0;
                    ack0_nx  = g0;
                    ack1_nx  = g1;
                    last_nx  = g1;
                end
            end
            SETUP: begin
                if (cnt == DIV_END) begin
                    state_nx = SHIFT;
                    cnt_nx   = '0;
                    pulse_nx = '0;
                    sclk_nx  = 1'b1;
                end
            end
            SHIFT: begin
                if (cnt == DIV_END) begin
                    cnt_nx = '0;
                    // copi moves only with the falling sclk; the shifted-in zero feeds the commit pulse
                    if (sclk_q) begin
                        sclk_nx  = 1'b0;
                        copi_nx  = shreg[14];
                        shreg_nx = {shreg[13:0], 1'b0};
                    end else if (pulse == LAST_PULSE) begin
                        state_nx = GAP;
                        cs_n_nx  = 1'b1;
                        copi_nx  = 1'b0;
                        done_nx  = 1'b1;
                    end else begin
                        sclk_nx  = 1'b1;
                        pulse_nx = pulse + 5'd1;
                    end
                end
            end
            GAP: begin
                if (cnt == GAP_END) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            pulse  <= '0;
            shreg  <= '0;
            last   <= 1'b1;
            sclk_q <= 1'b0;
            copi_q <= 1'b0;
            cs_n_q <= 1'b1;
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            done_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            pulse  <= pulse_nx;
            shreg  <= shreg_nx;
            last   <= last_nx;
            sclk_q <= sclk_nx;
            copi_q <= copi_nx;
            cs_n_q <= cs_n_nx;
            ack0_q <= ack0_nx;
            ack1_q <= ack1_nx;
            done_q <= done_nx;
            busy_q <= state_nx != IDLE;
        end
    end

    assign bus.sclk = sclk_q;
    assign bus.copi = copi_q;
    assign bus.cs_n = cs_n_q;
    assign bus.ack0 = ack0_q;
    assign bus.ack1 = ack1_q;
    assign bus.done = done_q;
    assign bus.busy = busy_q;

    a_one_ack: assert property (@(posedge clk) disable iff (!rst_n) !(ack0_q && ack1_q));
endmodule

// File: tb/tb_spi_write_sequencer.sv
// tb_spi_write_sequencer: randomized requesters against a frame-level arbitration model
// and an SPI peripheral model that decodes the wire and commits on the 17th rising sclk.
module tb_spi_write_sequencer;
    localparam int CLK_DIV    = 4;
    localparam int GAP_CYCLES = 8;
    localparam int ACK_GAP    = 35 * CLK_DIV + GAP_CYCLES + 1;

    logic clk = 1'b0;
    logic rst_n;
    spi_write_sequencer_if bus();

    spi_write_sequencer #(.CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP_CYCLES)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    logic [16:0] bits;
    logic [15:0] pend, last_frame;
    logic        in_frame = 1'b0, pend_v = 1'b0, m_last = 1'b1, mb_frame = 1'b0, w1;
    logic        prev_sclk = 1'b0, prev_cs = 1'b1, prev_copi = 1'b0;
    logic        s_req0 = 1'b0, s_req1 = 1'b0;
    logic [6:0]  s_addr0, s_addr1;
    logic [7:0]  s_data0, s_data1;
    int          mon_rises = 0, low_cnt = 0, ack_cnt = 0, frm_cnt = 0, done_cnt = 0;
    int          cyc = 0, last_ack = 0, gap_left = 0, bad = 0;
    logic [15:0] frames[$];
    int          grants[$], ack_gaps[$];
    logic [7:0]  obs_regs[5] = '{default: 8'h00};
    logic [7:0]  exp_regs[5] = '{default: 8'h00};

    // monitor, arbitration model and peripheral model, all sampled away from the active edge
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            in_frame = 1'b0; pend_v = 1'b0; m_last = 1'b1; mb_frame = 1'b0; gap_left = 0;
        end else begin
            if (bus.ack0 || bus.ack1) begin
                w1 = s_req1 && (!s_req0 || !m_last);
                check("ack_who", {bus.ack1, bus.ack0}, w1 ? 2'b10 : 2'b01);
                if (!(s_req0 || s_req1)) bad++;
                m_last = w1;
                pend = {1'b1, w1 ? s_addr1 : s_addr0, w1 ? s_data1 : s_data0};
                pend_v = 1'b1;
                ack_cnt++;
                grants.push_back(int'(bus.ack1));
                ack_gaps.push_back(cyc - last_ack);
                last_ack = cyc;
                mb_frame = 1'b1;
            end
            if (prev_cs && !bus.cs_n) begin
                in_frame = 1'b1; mon_rises = 0; bits = '0; low_cnt = 0;
            end
            if (!bus.cs_n) low_cnt++;
            if (bus.sclk && !prev_sclk && !bus.cs_n) begin
                mon_rises++;
                bits = {bits[15:0], bus.copi};
                if (mon_rises == 17 && bits[16] && bits[15:9] < 7'd5) obs_regs[bits[15:9]] = bits[8:1];
            end
            if (!prev_cs && bus.cs_n && in_frame) begin
                in_frame = 1'b0;
                frm_cnt++;
                check("frame_pend", pend_v, 1);
                check("frame_word", bits[16:1], pend);
                check("frame_rises", mon_rises, 17);
                check("commit_bit", bits[0], 0);
                check("cs_low", low_cnt, 35 * CLK_DIV);
                check("done_edge", bus.done, 1);
                if (pend[14:8] < 7'd5) exp_regs[pend[14:8]] = pend[7:0];
                last_frame = bits[16:1];
                frames.push_back(bits[16:1]);
                pend_v = 1'b0;
            end
            if (bus.done) begin
                done_cnt++; mb_frame = 1'b0; gap_left = GAP_CYCLES;
            end
            if (bus.busy !== (mb_frame || gap_left > 0)) bad++;
            if (gap_left > 0) gap_left--;
            if (bus.ack0 && bus.ack1) bad++;
            if (bus.cs_n && (bus.sclk || bus.copi)) bad++;
            if (bus.copi !== prev_copi && !(prev_sclk && !bus.sclk) && !(prev_cs && !bus.cs_n)) bad++;
        end
        prev_sclk = bus.sclk; prev_cs = bus.cs_n; prev_copi = bus.copi;
        s_req0 = bus.req0; s_req1 = bus.req1;
        s_addr0 = bus.addr0; s_addr1 = bus.addr1; s_data0 = bus.data0; s_data1 = bus.data1;
    end

    task automatic drive(input int who, input logic [6:0] a, input logic [7:0] d);
        int n = 0;
        @(posedge clk); #2;
        if (who == 0) begin bus.req0 = 1'b1; bus.addr0 = a; bus.data0 = d; end
        else begin bus.req1 = 1'b1; bus.addr1 = a; bus.data1 = d; end
        do begin @(negedge clk); n++; end while (!(who == 0 ? bus.ack0 : bus.ack1) && n < 2000);
        if (n >= 2000) check("ack_timeout", 0, 1);
        @(posedge clk); #2;
        if (who == 0) bus.req0 = 1'b0; else bus.req1 = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin @(negedge clk); n++; end while ((bus.busy || bus.req0 || bus.req1) && n < 5000);
        if (n >= 5000) check("idle_timeout", 0, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk); #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    int n_sent = 0, d0, f0, a0, g0, n, mode;
    logic [7:0] r1, snap[5];
    logic [6:0] ra0, ra1;
    logic [7:0] rd0, rd1;

    initial begin
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.addr0 = '0; bus.addr1 = '0; bus.data0 = '0; bus.data1 = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 check("reset_lines", {bus.cs_n, bus.sclk, bus.copi, bus.ack0, bus.ack1, bus.busy, bus.done}, 7'b1000000);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // single write to the duty-cycle register
        d0 = done_cnt;
        drive(0, 7'h04, 8'hA5); n_sent++;
        wait_idle();
        check("t1_word", last_frame, 16'h84A5);
        check("t1_done", done_cnt - d0, 1);
        check("t1_reg4", obs_regs[4], 8'hA5);

        // both held after reset: requester 0 first, then strict alternation
        do_reset();
        f0 = frames.size(); g0 = grants.size();
        fork
            begin
                drive(0, 7'h00, 8'hFF);
                drive(0, 7'($urandom_range(0, 7)), 8'($urandom));
                drive(0, 7'($urandom_range(0, 7)), 8'($urandom));
            end
            begin
                drive(1, 7'h01, 8'h3C);
                drive(1, 7'($urandom_range(0, 7)), 8'($urandom));
                drive(1, 7'($urandom_range(0, 7)), 8'($urandom));
            end
        join
        n_sent += 6;
        wait_idle();
        check("t2_first", frames[f0], 16'h80FF);
        check("t2_second", frames[f0 + 1], 16'h813C);
        for (int i = 0; i < 6; i++) check("t2_alt", grants[g0 + i], i % 2);

        // back-to-back from requester 1
        d0 = done_cnt;
        drive(1, 7'h02, 8'h11);
        drive(1, 7'h03, 8'h22);
        drive(1, 7'h04, 8'h33);
        n_sent += 3;
        wait_idle();
        check("t3_spacing_a", ack_gaps[ack_gaps.size() - 2], ACK_GAP);
        check("t3_spacing_b", ack_gaps[ack_gaps.size() - 1], ACK_GAP);
        check("t3_reg2", obs_regs[2], 8'h11);
        check("t3_reg3", obs_regs[3], 8'h22);
        check("t3_reg4", obs_regs[4], 8'h33);
        check("t3_done", done_cnt - d0, 3);

        // reset in the middle of a frame
        r1 = obs_regs[1];
        drive(1, 7'h01, 8'h55); n_sent++;
        n = 0;
        do begin @(negedge clk); n++; end while (!(in_frame && mon_rises == 9) && n < 1000);
        check("t4_reach9", mon_rises, 9);
        #3 rst_n = 1'b0;
        d0 = done_cnt;
        #1 check("t4_lines", {bus.cs_n, bus.sclk, bus.busy}, 3'b100);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("t4_nodone", done_cnt - d0, 0);
        check("t4_reg1_kept", obs_regs[1], r1);
        drive(1, 7'h01, 8'h55); n_sent++;
        wait_idle();
        check("t4_retry", last_frame, 16'h8155);
        check("t4_reg1", obs_regs[1], 8'h55);

        // payload changed while waiting: grant-edge value is sent
        drive(1, 7'h04, 8'h10); n_sent++;
        @(posedge clk); #2 bus.req0 = 1'b1; bus.addr0 = 7'h00; bus.data0 = 8'h99;
        repeat (30) @(posedge clk);
        #2 bus.addr0 = 7'h02; bus.data0 = 8'h77;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.ack0 && n < 2000);
        check("t5_ack", bus.ack0, 1);
        @(posedge clk); #2 bus.req0 = 1'b0; n_sent++;
        wait_idle();
        check("t5_word", last_frame, 16'h8277);

        // withdrawn request leaves no trace
        a0 = ack_cnt; f0 = frm_cnt;
        drive(1, 7'h03, 8'h44); n_sent++;
        @(posedge clk); #2 bus.req0 = 1'b1; bus.addr0 = 7'h03; bus.data0 = 8'hEE;
        repeat (20) @(posedge clk);
        #2 bus.req0 = 1'b0;
        wait_idle();
        repeat (200) @(negedge clk);
        check("t5_acks", ack_cnt - a0, 1);
        check("t5_frames", frm_cnt - f0, 1);
        check("t5_reg3", obs_regs[3], 8'h44);

        // unmapped address
        for (int i = 0; i < 5; i++) snap[i] = obs_regs[i];
        drive(0, 7'h7F, 8'h5A); n_sent++;
        wait_idle();
        check("t6_word", last_frame, 16'hFF5A);
        for (int i = 0; i < 5; i++) check("t6_regs", obs_regs[i], snap[i]);

        // random requester mix
        for (int i = 0; i < 12; i++) begin
            mode = $urandom_range(0, 2);
            ra0 = 7'($urandom_range(0, 7)); ra1 = 7'($urandom_range(0, 7));
            rd0 = 8'($urandom); rd1 = 8'($urandom);
            repeat ($urandom_range(0, 5)) @(posedge clk);
            if (mode == 0) drive(0, ra0, rd0);
            else if (mode == 1) drive(1, ra1, rd1);
            else fork drive(0, ra0, rd0); drive(1, ra1, rd1); join
            n_sent += (mode == 2) ? 2 : 1;
            wait_idle();
        end

        check("protocol", bad, 0);
        check("ack_total", ack_cnt, n_sent);
        check("done_total", done_cnt, frm_cnt);
        for (int i = 0; i < 5; i++) check("final_regs", obs_regs[i], exp_regs[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
